// File: rtl/mux_sseg_ndig.sv
// Time-multiplexed N-digit seven-segment driver with per-slot PWM brightness.
// Inputs are snapshotted at each slot start; all display outputs are registered.
module mux_sseg_ndig #(
    parameter int N_DIG    = 4,
    parameter int SLOT_W   = 16,
    parameter int BRIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*N_DIG-1:0]    dig_in,
    input  logic [N_DIG-1:0]      blank,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [N_DIG-1:0]      en_dig,
    output logic [7:0]            sseg,
    output logic [3:0]            cur_dig,
    output logic                  frame_tick
);

    localparam logic [3:0] LAST_IDX = 4'(N_DIG - 1);

    logic [SLOT_W-1:0]   cnt_r;
    logic [3:0]          idx_r;
    logic [7:0]          lat_pat_r;
    logic                lat_blank_r;
    logic [BRIGHT_W-1:0] lat_bright_r;

    logic                slot_start_s;
    logic                slot_end_s;
    logic                frame_end_s;
    logic                lit_s;
    logic [BRIGHT_W-1:0] phase_s;
    logic [7:0]          sel_pat_s;
    logic                sel_blank_s;
    logic [N_DIG-1:0]    en_dig_s;
    logic [7:0]          sseg_s;

    // Slot decode, input digit selection and next-cycle display values.
    always_comb begin
        slot_start_s = (cnt_r == {SLOT_W{1'b0}});
        slot_end_s   = (cnt_r == {SLOT_W{1'b1}});
        frame_end_s  = slot_end_s && (idx_r == LAST_IDX);
        phase_s      = cnt_r[SLOT_W-1 -: BRIGHT_W];
        sel_pat_s    = 8'h00;
        sel_blank_s  = 1'b0;
        // AND-OR mux: idx never exceeds N_DIG-1, so exactly one term is selected.
        for (int i = 0; i < N_DIG; i++) begin
            sel_pat_s   = sel_pat_s | (dig_in[8*i +: 8] & {8{idx_r == 4'(i)}});
            sel_blank_s = sel_blank_s | (blank[i] & (idx_r == 4'(i)));
        end
        // The first clock of every slot stays dark to avoid ghosting on digit change.
        lit_s = !slot_start_s && !lat_blank_r &&
                ((&lat_bright_r) || (phase_s < lat_bright_r));
        for (int i = 0; i < N_DIG; i++) begin
            en_dig_s[i] = ~(lit_s && (idx_r == 4'(i)));
        end
        sseg_s = lit_s ? lat_pat_r : 8'hFF;
    end

    // Scan state, slot snapshot and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r        <= {SLOT_W{1'b0}};
            idx_r        <= 4'd0;
            lat_pat_r    <= 8'hFF;
            lat_blank_r  <= 1'b1;
            lat_bright_r <= {BRIGHT_W{1'b0}};
            en_dig       <= {N_DIG{1'b1}};
            sseg         <= 8'hFF;
            cur_dig      <= 4'd0;
            frame_tick   <= 1'b0;
        end else begin
            cnt_r <= cnt_r + SLOT_W'(1);
            if (slot_end_s) begin
                idx_r <= (idx_r == LAST_IDX) ? 4'd0 : idx_r + 4'd1;
            end else begin
                idx_r <= idx_r;
            end
            if (slot_start_s) begin
                lat_pat_r    <= sel_pat_s;
                lat_blank_r  <= sel_blank_s;
                lat_bright_r <= bright;
            end else begin
                lat_pat_r    <= lat_pat_r;
                lat_blank_r  <= lat_blank_r;
                lat_bright_r <= lat_bright_r;
            end
            en_dig     <= en_dig_s;
            sseg       <= sseg_s;
            cur_dig    <= idx_r;
            frame_tick <= frame_end_s;
        end
    end

endmodule
